// File: rtl/irq_priority_encoder.sv
// irq_priority_encoder
//
// Eight-source priority interrupt encoder (source 7 highest, 74x148 style).
// Active-low requests are captured into a pending register (edge-latched or
// level-mirrored, selected by EDGE). The highest-numbered unmasked pending
// source is presented to the CPU under an irq/ack/eoi handshake. 74x148-style
// cascade status (gs_n, eo_n) allows chaining a second encoder.
//
// Ports:
//   i_clk    system clock, all state on the rising edge
//   i_rst    synchronous reset, active-high
//   i_req_n  [7:0] interrupt requests, active-low, bit i = source i
//   i_ei_n   enable input, active-low; high blocks new assertions
//   i_mask   [7:0] per-source mask, 1 = source ignored for selection
//   i_ack    CPU acknowledge pulse (honoured only while asserting)
//   i_eoi    CPU end-of-interrupt pulse (honoured only while in service)
//   o_irq    registered interrupt request to the CPU
//   o_vec    [2:0] registered selected source number
//   o_busy   registered, a source is in service
//   o_gs_n   group select, low when enabled and an unmasked source is pending
//   o_eo_n   enable output, low when enabled and nothing unmasked is pending

module irq_priority_encoder #(
  parameter bit EDGE = 1'b1
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_req_n,
  input  logic       i_ei_n,
  input  logic [7:0] i_mask,
  input  logic       i_ack,
  input  logic       i_eoi,
  output logic       o_irq,
  output logic [2:0] o_vec,
  output logic       o_busy,
  output logic       o_gs_n,
  output logic       o_eo_n
);

  typedef enum logic [1:0] {
    StIdle,
    StAssert,
    StService
  } state_e;

  state_e     r_state;
  logic [7:0] r_req_q;
  logic [7:0] r_pend;
  logic [2:0] r_vec;
  logic       r_irq;
  logic       r_busy;

  state_e     w_state_d;
  logic [7:0] w_pend_d;
  logic [2:0] w_vec_d;
  logic       w_irq_d;
  logic       w_busy_d;

  logic [7:0] w_act;
  logic       w_any;
  logic [2:0] w_sel;
  logic       w_ack_ok;
  logic [7:0] w_clr;

  assign w_act    = r_pend & ~i_mask;
  assign w_any    = |w_act;
  assign w_ack_ok = (r_state == StAssert) && i_ack;

  // Highest set bit of w_act; later iterations override earlier ones.
  always_comb begin
    w_sel = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (w_act[i]) w_sel = 3'(i);
    end
  end

  // Pending capture. In edge mode a fresh fall on the bit being acknowledged
  // is kept (set wins over clear).
  always_comb begin
    w_clr = 8'h00;
    if (EDGE && w_ack_ok) w_clr[r_vec] = 1'b1;
    if (EDGE) begin
      w_pend_d = (r_pend & ~w_clr) | (r_req_q & ~i_req_n);
    end else begin
      w_pend_d = ~i_req_n;
    end
  end

  // Handshake FSM next state and registered outputs.
  always_comb begin
    w_state_d = r_state;
    w_vec_d   = r_vec;
    w_irq_d   = r_irq;
    w_busy_d  = r_busy;
    unique case (r_state)
      StIdle: begin
        if (!i_ei_n && w_any) begin
          w_vec_d   = w_sel;
          w_irq_d   = 1'b1;
          w_state_d = StAssert;
        end
      end
      StAssert: begin
        // vec frozen here; ack beats a disable.
        if (i_ack) begin
          w_irq_d   = 1'b0;
          w_busy_d  = 1'b1;
          w_state_d = StService;
        end else if (i_ei_n) begin
          w_irq_d   = 1'b0;
          w_state_d = StIdle;
        end
      end
      StService: begin
        if (i_eoi) begin
          w_busy_d  = 1'b0;
          w_state_d = StIdle;
        end
      end
      default: begin
        w_state_d = StIdle;
        w_irq_d   = 1'b0;
        w_busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      // The edge history follows the lines during reset so that a request
      // already held low at release is not seen as a new fall.
      r_req_q <= i_req_n;
      r_pend  <= 8'h00;
      r_state <= StIdle;
      r_vec   <= 3'd0;
      r_irq   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_req_q <= i_req_n;
      r_pend  <= w_pend_d;
      r_state <= w_state_d;
      r_vec   <= w_vec_d;
      r_irq   <= w_irq_d;
      r_busy  <= w_busy_d;
    end
  end

  assign o_irq  = r_irq;
  assign o_vec  = r_vec;
  assign o_busy = r_busy;
  assign o_gs_n = ~(~i_ei_n & w_any);
  assign o_eo_n = ~(~i_ei_n & ~w_any);

endmodule
